// File: rtl/muldiv_seq_ctrl_if.sv
// Bundle between the EX-stage multiply/divide sequencer, its requester and
// the shared ripple-carry adder it borrows once per iteration.
interface muldiv_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    // request side
    logic             start;
    logic             mode;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // status and result side
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // shared adder side
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_op;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    // the pipeline / adder environment around the sequencer
    modport master (
        output start, mode, flush, a, b,
        input  busy, done, div_zero, hi, lo,
        input  add_x, add_y, add_op,
        output add_s, add_co
    );

    // the sequencer itself
    modport slave (
        input  start, mode, flush, a, b,
        output busy, done, div_zero, hi, lo,
        output add_x, add_y, add_op,
        input  add_s, add_co
    );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MULTU / DIVU sequencer for the EX stage. Shift-add multiply and
// restoring divide run over WIDTH iterations using one external adder; the
// result is parked in HI/LO until the next completed operation.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start
// S_ITER | one adder iteration per cycle, cnt = 0 .. WIDTH-1
// S_DONE | single-cycle completion, done=1, start accepted for back-to-back
module muldiv_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic             mode_q;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             div_zero_q;

    logic             accept;
    logic             dz_accept;
    logic             last_iter;
    logic [WIDTH-1:0] sh;
    logic             ge;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] add_x_c;
    logic [WIDTH-1:0] add_y_c;
    logic             add_op_c;

    // Start is only honoured outside ITER and loses to flush; a zero divisor
    // short-circuits straight to DONE.
    always_comb begin
        accept    = 1'b0;
        dz_accept = 1'b0;
        last_iter = 1'b0;
        if (state != S_ITER && bus.start && !bus.flush) begin
            accept    = 1'b1;
            dz_accept = bus.mode && (bus.b == '0);
        end
        if (state == S_ITER && cnt == CW'(WIDTH - 1)) begin
            last_iter = 1'b1;
        end
    end

    // Next-state decode; flush overrides everything except reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = dz_accept ? S_DONE : S_ITER;
            end
            S_ITER: begin
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (accept) state_nxt = dz_accept ? S_DONE : S_ITER;
                else        state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Adder operand steering and iteration update. The divide path treats
    // R[MSB] as a 17th sum bit: if it is set the shifted remainder already
    // exceeds any WIDTH-bit divisor.
    always_comb begin
        add_x_c  = '0;
        add_y_c  = '0;
        add_op_c = 1'b0;
        r_nxt    = r_q;
        q_nxt    = q_q;
        sh       = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        ge       = r_q[WIDTH-1] | bus.add_co;
        if (state == S_ITER) begin
            if (!mode_q) begin
                add_x_c  = r_q;
                add_y_c  = q_q[0] ? d_q : '0;
                add_op_c = 1'b0;
                r_nxt    = {bus.add_co, bus.add_s[WIDTH-1:1]};
                q_nxt    = {bus.add_s[0], q_q[WIDTH-1:1]};
            end else begin
                add_x_c  = sh;
                add_y_c  = ~d_q;
                add_op_c = 1'b1;
                r_nxt    = ge ? bus.add_s : sh;
                q_nxt    = {q_q[WIDTH-2:0], ge};
            end
        end
    end

    // Working registers and the HI/LO result, captured only on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= '0;
            q_q        <= '0;
            d_q        <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else if (bus.flush) begin
            cnt        <= cnt;
        end else if (accept) begin
            r_q    <= '0;
            q_q    <= bus.a;
            d_q    <= bus.b;
            cnt    <= '0;
            mode_q <= bus.mode;
            if (dz_accept) begin
                hi_q       <= bus.a;
                lo_q       <= '1;
                div_zero_q <= 1'b1;
            end
        end else if (state == S_ITER) begin
            r_q <= r_nxt;
            q_q <= q_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                hi_q       <= r_nxt;
                lo_q       <= q_nxt;
                div_zero_q <= 1'b0;
            end
        end
    end

    assign bus.busy     = (state == S_ITER);
    assign bus.done     = (state == S_DONE);
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.add_x    = add_x_c;
    assign bus.add_y    = add_y_c;
    assign bus.add_op   = add_op_c;
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Bench for muldiv_seq_ctrl: behavioural shared adder, a table of MULTU/DIVU
// vectors with hand-computed results, and directed multi-cycle sequences.
module tb_muldiv_seq_ctrl;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // external ripple-carry adder: carry-in is add_op, Y already inverted by the DUT
    assign {bus.add_co, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + 17'(bus.add_op);

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
        logic        exp_dz;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request for one cycle starting at the current negedge.
    task automatic launch(input logic m, input logic [15:0] av, input logic [15:0] bv);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'h0000;
    endtask

    // From the current negedge, count busy cycles until done (bounded).
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            chk("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op(input logic m, input logic [15:0] av, input logic [15:0] bv,
                          output int nbusy, output bit got);
        @(negedge clk);
        launch(m, av, bv);
        wait_done(nbusy, got);
    endtask

    initial begin
        int  nb;
        int  nb0;
        bit  got;
        bit  saw_done;

        vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 16};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 16};
        vecs[2] = '{1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 16};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 16};
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 0};
        vecs[5] = '{1'b0, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 16};
        vecs[6] = '{1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16};
        vecs[7] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 16};
        vecs[8] = '{1'b1, 16'd5,    16'd10,   16'h0005, 16'h0000, 1'b0, 16};
        vecs[9] = '{1'b0, 16'h0100, 16'h0100, 16'h0001, 16'h0000, 1'b0, 16};

        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.flush = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_dz",   32'(bus.div_zero), 0);
        chk("rst_hi",   32'(bus.hi), 0);
        chk("rst_lo",   32'(bus.lo), 0);
        chk("idle_add_x",  32'(bus.add_x), 0);
        chk("idle_add_y",  32'(bus.add_y), 0);
        chk("idle_add_op", 32'(bus.add_op), 0);

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, nb, got);
            chk($sformatf("v%0d_done", i), 32'(got), 1);
            chk($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_hi", i), 32'(bus.hi), 32'(vecs[i].exp_hi));
            chk($sformatf("v%0d_lo", i), 32'(bus.lo), 32'(vecs[i].exp_lo));
            chk($sformatf("v%0d_dz", i), 32'(bus.div_zero), 32'(vecs[i].exp_dz));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 0);
            chk($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 0);
            chk($sformatf("v%0d_hold_hi", i), 32'(bus.hi), 32'(vecs[i].exp_hi));
            chk($sformatf("v%0d_idle_add_op", i), 32'(bus.add_op), 0);
        end

        // start held during ITER is ignored
        @(negedge clk);
        launch(1'b0, 16'h1234, 16'h5678);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.a     = 16'h0003;
        bus.b     = 16'h0003;
        nb0 = 0;
        repeat (5) begin
            if (bus.busy) nb0++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done(nb, got);
        chk("held_start_done", 32'(got), 1);
        chk("held_start_busy", 32'(nb0 + nb), 16);
        chk("held_start_hi", 32'(bus.hi), 32'h0626);
        chk("held_start_lo", 32'(bus.lo), 32'h0060);

        // back-to-back: start in the DONE cycle, no IDLE gap
        launch(1'b1, 16'd100, 16'd7);
        chk("b2b_busy_now", 32'(bus.busy), 1);
        wait_done(nb, got);
        chk("b2b_done", 32'(got), 1);
        chk("b2b_busy_cycles", 32'(nb), 16);
        chk("b2b_hi", 32'(bus.hi), 32'h0002);
        chk("b2b_lo", 32'(bus.lo), 32'h000E);

        // flush beats start in the DONE cycle
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 16'h0003;
        bus.b     = 16'h0005;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush_start_busy", 32'(bus.busy), 0);
        chk("flush_start_done", 32'(bus.done), 0);

        // known prior result, then flush at iteration 8
        run_op(1'b0, 16'h0003, 16'h0005, nb, got);
        chk("prior_lo", 32'(bus.lo), 32'h000F);
        @(negedge clk);
        launch(1'b0, 16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        chk("flush_pre_busy", 32'(bus.busy), 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", 32'(bus.busy), 0);
        chk("flush_done", 32'(bus.done), 0);
        saw_done = 1'b0;
        repeat (20) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(saw_done), 0);
        chk("flush_hi", 32'(bus.hi), 32'h0000);
        chk("flush_lo", 32'(bus.lo), 32'h000F);

        // divide by zero then reset mid-divide
        run_op(1'b1, 16'h1234, 16'h0000, nb, got);
        chk("dz2_busy_cycles", 32'(nb), 0);
        chk("dz2_flag", 32'(bus.div_zero), 1);
        @(negedge clk);
        launch(1'b1, 16'd100, 16'd7);
        chk("div_it0_add_x",  32'(bus.add_x), 32'h0000);
        chk("div_it0_add_y",  32'(bus.add_y), 32'hFFF8);
        chk("div_it0_add_op", 32'(bus.add_op), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_dz",   32'(bus.div_zero), 0);
        chk("midrst_hi",   32'(bus.hi), 0);
        chk("midrst_lo",   32'(bus.lo), 0);
        chk("midrst_add_x",  32'(bus.add_x), 0);
        chk("midrst_add_y",  32'(bus.add_y), 0);
        chk("midrst_add_op", 32'(bus.add_op), 0);
        @(negedge clk);
        chk("midrst_stays_idle", 32'(bus.busy | bus.done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
